soc_bus_arbiter: RTL and testbench

//  Shares the single SoC memory bus (mem_addr/wdata/wmask/wstrb/rstrb/rdata/done) between
//  NUM_REQ masters (cores, future DMA). Round-robin, one transaction in flight, grant held

---
 rtl/soc_bus_pkg.sv | 9 +
 rtl/soc_bus_arbiter_rr_pick.sv | 22 ++
 rtl/soc_bus_arbiter.sv | 90 +++++++++
 tb/tb_soc_bus_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/soc_bus_pkg.sv
// soc_bus_pkg: shared types, bus width defaults and counter sizing for SoC bus arbitration.
package soc_bus_pkg;
    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} arb_state_e;
    localparam int SOC_ADDR_WIDTH = 32;
    localparam int SOC_DATA_WIDTH = 32;
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction
endpackage

// File: rtl/soc_bus_arbiter_rr_pick.sv
// rr_pick: combinational round-robin search for the first active requester after last.
module rr_pick import soc_bus_pkg::*; #(
    parameter int NUM_REQ = 2,
    localparam int IW = cnt_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] active,
    input  logic [IW-1:0]      last,
    output logic [IW-1:0]      winner,
    output logic               any
);
    int idx;
    // Walk from farthest to nearest so the closest active index after last wins.
    always_comb begin
        winner = '0;
        idx = 0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            idx = (int'(last) + i) % NUM_REQ;
            if (active[IW'(idx)]) winner = IW'(idx);
        end
    end
    assign any = |active;
endmodule

// File: rtl/soc_bus_arbiter.sv
// soc_bus_arbiter: round-robin sharing of the SoC memory bus between NUM_REQ masters,
// one transaction in flight, with a watchdog aborting transactions that never complete.
module soc_bus_arbiter import soc_bus_pkg::*; #(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = SOC_ADDR_WIDTH,
    parameter int DATA_WIDTH = SOC_DATA_WIDTH,
    parameter int TIMEOUT    = 1024
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_wdata,
    input  logic [NUM_REQ*DATA_WIDTH/8-1:0] req_wmask,
    input  logic [NUM_REQ-1:0]              req_wstrb,
    input  logic [NUM_REQ-1:0]              req_rstrb,
    output logic [DATA_WIDTH-1:0]           req_rdata,
    output logic [NUM_REQ-1:0]              req_done,
    output logic [NUM_REQ-1:0]              req_err,
    output logic [ADDR_WIDTH-1:0]           mem_addr,
    output logic [DATA_WIDTH-1:0]           mem_wdata,
    output logic [DATA_WIDTH/8-1:0]         mem_wmask,
    output logic                            mem_wstrb,
    output logic                            mem_rstrb,
    input  logic [DATA_WIDTH-1:0]           mem_rdata,
    input  logic                            mem_done
);
    localparam int IW = cnt_width(NUM_REQ);
    localparam int WW = cnt_width(TIMEOUT);
    localparam int MW = DATA_WIDTH / 8;
    arb_state_e state;
    logic [IW-1:0] grant;
    logic [IW-1:0] last;
    logic [IW-1:0] winner;
    logic [WW-1:0] wdog;
    logic [NUM_REQ-1:0] active;
    logic [NUM_REQ-1:0] grant_1h;
    logic any;
    logic busy;
    logic g_active;
    logic expired;
    logic finish;
    logic abort;

    rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .active(active),
        .last(last),
        .winner(winner),
        .any(any)
    );

    assign active    = req_wstrb | req_rstrb;
    assign busy      = (state == BUSY);
    assign g_active  = active[grant];
    assign grant_1h  = NUM_REQ'(1) << grant;
    assign expired   = (TIMEOUT != 0) && (wdog == WW'(TIMEOUT - 1));
    // A completing slave in the expiry cycle takes priority over the abort.
    assign finish    = busy && g_active && mem_done;
    assign abort     = busy && g_active && !mem_done && expired;

    assign mem_addr  = req_addr[grant*ADDR_WIDTH +: ADDR_WIDTH];
    assign mem_wdata = req_wdata[grant*DATA_WIDTH +: DATA_WIDTH];
    assign mem_wmask = req_wmask[grant*MW +: MW];
    assign mem_wstrb = busy && req_wstrb[grant];
    assign mem_rstrb = busy && req_rstrb[grant];
    assign req_rdata = mem_rdata;
    assign req_done  = (finish || abort) ? grant_1h : '0;
    assign req_err   = abort ? grant_1h : '0;

    // A granted master dropping its strobe without done releases the bus silently.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            grant <= '0;
            last  <= IW'(NUM_REQ - 1);
            wdog  <= '0;
        end else if (!busy) begin
            wdog <= '0;
            if (any) begin
                state <= BUSY;
                grant <= winner;
                last  <= winner;
            end
        end else if (finish || abort || !g_active) begin
            state <= IDLE;
            wdog  <= '0;
        end else begin
            wdog <= wdog + 1'b1;
        end
    end
endmodule

// File: tb/tb_soc_bus_arbiter.sv
// tb_soc_bus_arbiter: directed scoreboard bench for soc_bus_arbiter (arbitration, timing,
// reset abort, strobe-drop release) plus a TIMEOUT=16 instance for the watchdog.
module tb_soc_bus_arbiter;
    import soc_bus_pkg::*;

    typedef struct {
        logic [1:0]  done;
        logic [1:0]  err;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wmask;
        logic        wstrb;
        logic        rstrb;
        logic [31:0] rdata;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [31:0] m_addr [2];
    logic [31:0] m_wdata [2];
    logic [3:0]  m_wmask [2];
    logic [1:0]  req_wstrb = '0;
    logic [1:0]  req_rstrb = '0;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic [7:0]  req_wmask;
    logic [31:0] req_rdata;
    logic [1:0]  req_done;
    logic [1:0]  req_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_wstrb;
    logic        mem_rstrb;
    logic [31:0] mem_rdata;
    logic        mem_done;

    assign req_addr  = {m_addr[1], m_addr[0]};
    assign req_wdata = {m_wdata[1], m_wdata[0]};
    assign req_wmask = {m_wmask[1], m_wmask[0]};

    // Slave model: answers after lat strobe cycles, read data is the inverted address.
    int lat = 0;
    int scnt = 0;
    assign mem_done  = (mem_wstrb || mem_rstrb) && (scnt >= lat);
    assign mem_rdata = ~mem_addr;
    always @(posedge clk) scnt <= ((mem_wstrb || mem_rstrb) && !mem_done) ? scnt + 1 : 0;

    soc_bus_arbiter #(.NUM_REQ(2), .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(1024)) dut (
        .clk(clk), .reset(reset),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
        .req_wstrb(req_wstrb), .req_rstrb(req_rstrb),
        .req_rdata(req_rdata), .req_done(req_done), .req_err(req_err),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_wstrb(mem_wstrb), .mem_rstrb(mem_rstrb),
        .mem_rdata(mem_rdata), .mem_done(mem_done)
    );

    logic [63:0] t_addr = {32'h0, 32'h0700_0000};
    logic [63:0] t_wdata = '0;
    logic [7:0]  t_wmask = '0;
    logic [1:0]  t_wstrb = '0;
    logic [1:0]  t_rstrb = '0;
    logic [31:0] t_rdata;
    logic [1:0]  t_done;
    logic [1:0]  t_err;
    logic [31:0] t_maddr;
    logic [31:0] t_mwdata;
    logic [3:0]  t_mwmask;
    logic        t_mwstrb;
    logic        t_mrstrb;
    logic        t_mdone = 1'b0;

    soc_bus_arbiter #(.NUM_REQ(2), .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(16)) dut_t (
        .clk(clk), .reset(reset),
        .req_addr(t_addr), .req_wdata(t_wdata), .req_wmask(t_wmask),
        .req_wstrb(t_wstrb), .req_rstrb(t_rstrb),
        .req_rdata(t_rdata), .req_done(t_done), .req_err(t_err),
        .mem_addr(t_maddr), .mem_wdata(t_mwdata), .mem_wmask(t_mwmask),
        .mem_wstrb(t_mwstrb), .mem_rstrb(t_mrstrb),
        .mem_rdata(32'h0), .mem_done(t_mdone)
    );

    int n_cmp = 0;
    int n_bad = 0;
    exp_t sb[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int i, input logic wr, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] m);
        m_addr[i]    = a;
        m_wdata[i]   = d;
        m_wmask[i]   = m;
        req_wstrb[i] = wr;
        req_rstrb[i] = !wr;
    endtask

    task automatic release_req(input int i);
        req_wstrb[i] = 1'b0;
        req_rstrb[i] = 1'b0;
    endtask

    task automatic expect_tx(input int i, input logic wr, input logic [31:0] a,
                             input logic [31:0] d, input logic [3:0] m);
        exp_t e;
        e.done  = 2'b01 << i;
        e.err   = 2'b00;
        e.addr  = a;
        e.wdata = d;
        e.wmask = m;
        e.wstrb = wr;
        e.rstrb = !wr;
        e.rdata = ~a;
        sb.push_back(e);
    endtask

    task automatic wait_done(input int i, input int bound);
        for (int k = 0; k < bound; k++) begin
            @(negedge clk);
            if (req_done[i]) break;
        end
        chk($sformatf("done_seen_req%0d", i), req_done[i], 1);
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!reset && (|req_done || |req_err)) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", {req_err, req_done}, 0);
            end else begin
                e = sb.pop_front();
                chk("sb_done", req_done, e.done);
                chk("sb_err", req_err, e.err);
                chk("sb_addr", mem_addr, e.addr);
                chk("sb_wdata", mem_wdata, e.wdata);
                chk("sb_wmask", mem_wmask, e.wmask);
                chk("sb_wstrb", mem_wstrb, e.wstrb);
                chk("sb_rstrb", mem_rstrb, e.rstrb);
                chk("sb_rdata", req_rdata, e.rdata);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not finish, compared %0d", n_cmp);
        $fatal(1);
    end

    initial begin
        int early;
        int hits;
        for (int i = 0; i < 2; i++) begin
            m_addr[i]  = '0;
            m_wdata[i] = '0;
            m_wmask[i] = '0;
        end
        repeat (2) @(negedge clk);
        chk("por_wstrb", mem_wstrb, 0);
        chk("por_rstrb", mem_rstrb, 0);
        chk("por_done", req_done, 0);
        chk("por_err", req_err, 0);
        chk("por_state", dut.state, IDLE);
        chk("por_grant", dut.grant, 0);
        chk("por_last", dut.last, 1);
        tick();
        reset = 1'b0;

        // Reset in the middle of a transaction aborts it without a done.
        lat = 1000;
        drive(1, 1'b0, 32'h0600_0000, 32'h0, 4'h0);
        tick();
        @(negedge clk);
        chk("t1_busy_rstrb", mem_rstrb, 1);
        chk("t1_busy_grant", dut.grant, 1);
        #2;
        reset = 1'b1;
        #1;
        chk("t1_rst_rstrb", mem_rstrb, 0);
        chk("t1_rst_wstrb", mem_wstrb, 0);
        chk("t1_rst_done", req_done, 0);
        chk("t1_rst_err", req_err, 0);
        chk("t1_rst_state", dut.state, IDLE);
        chk("t1_rst_grant", dut.grant, 0);
        release_req(1);
        tick();
        tick();
        reset = 1'b0;

        // Single read with a same-cycle slave.
        lat = 0;
        expect_tx(0, 1'b0, 32'h0220_0000, 32'h0, 4'h0);
        drive(0, 1'b0, 32'h0220_0000, 32'h0, 4'h0);
        @(negedge clk);
        chk("t2_arb_cycle_rstrb", mem_rstrb, 0);
        tick();
        @(negedge clk);
        chk("t2_rstrb", mem_rstrb, 1);
        chk("t2_done_same_cycle", req_done, 2'b01);
        tick();
        release_req(0);
        @(negedge clk);
        chk("t2_idle_state", dut.state, IDLE);
        chk("t2_idle_rstrb", mem_rstrb, 0);

        // Both requesters continuously active from reset alternate 0,1,0,1.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int n = 0; n < 4; n++) begin
            if (n % 2 == 0) expect_tx(0, 1'b0, 32'h0000_1000, 32'h0, 4'h0);
            else expect_tx(1, 1'b1, 32'h0F00_0004, 32'h0000_CAFE, 4'h3);
        end
        drive(0, 1'b0, 32'h0000_1000, 32'h0, 4'h0);
        drive(1, 1'b1, 32'h0F00_0004, 32'h0000_CAFE, 4'h3);
        for (int n = 0; n < 4; n++) begin
            wait_done(n % 2, 20);
            tick();
        end
        release_req(0);
        release_req(1);

        // A write waits behind a slow flash read and then goes through intact.
        lat = 19;
        expect_tx(0, 1'b0, 32'h0300_0000, 32'h0, 4'h0);
        expect_tx(1, 1'b1, 32'h0F00_0000, 32'h0000_0001, 4'hF);
        drive(0, 1'b0, 32'h0300_0000, 32'h0, 4'h0);
        tick();
        drive(1, 1'b1, 32'h0F00_0000, 32'h0000_0001, 4'hF);
        early = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (mem_wstrb) early++;
            if (req_done[0]) break;
        end
        chk("t4_req1_held_off", early, 0);
        chk("t4_req0_done", req_done[0], 1);
        tick();
        release_req(0);
        wait_done(1, 40);
        tick();
        release_req(1);

        // Granted master drops its strobe: bus released, other master granted next.
        lat = 5;
        expect_tx(1, 1'b1, 32'h0500_0000, 32'h0000_0055, 4'h1);
        drive(0, 1'b0, 32'h0400_0000, 32'h0, 4'h0);
        drive(1, 1'b1, 32'h0500_0000, 32'h0000_0055, 4'h1);
        tick();
        @(negedge clk);
        chk("t6_grant0", dut.grant, 0);
        tick();
        release_req(0);
        @(negedge clk);
        chk("t6_no_done", req_done, 0);
        tick();
        @(negedge clk);
        chk("t6_idle_state", dut.state, IDLE);
        chk("t6_idle_wstrb", mem_wstrb, 0);
        tick();
        @(negedge clk);
        chk("t6_req1_wstrb", mem_wstrb, 1);
        chk("t6_req1_addr", mem_addr, 32'h0500_0000);
        wait_done(1, 20);
        tick();
        release_req(1);

        // Watchdog with TIMEOUT=16 and a silent slave.
        t_rstrb = 2'b01;
        hits = 0;
        for (int k = 1; k <= 15; k++) begin
            tick();
            @(negedge clk);
            if (t_done != 2'b00 || t_err != 2'b00) hits++;
        end
        chk("t5_quiet_first15", hits, 0);
        tick();
        @(negedge clk);
        chk("t5_abort_done", t_done, 2'b01);
        chk("t5_abort_err", t_err, 2'b01);
        chk("t5_abort_rstrb", t_mrstrb, 1);
        tick();
        t_rstrb = 2'b00;
        @(negedge clk);
        chk("t5_idle_state", dut_t.state, IDLE);
        chk("t5_idle_rstrb", t_mrstrb, 0);
        tick();
        // Done arriving exactly in the expiry cycle completes normally.
        t_rstrb = 2'b01;
        for (int k = 1; k <= 15; k++) tick();
        tick();
        t_mdone = 1'b1;
        @(negedge clk);
        chk("t5_late_done", t_done, 2'b01);
        chk("t5_late_err", t_err, 2'b00);
        tick();
        t_mdone = 1'b0;
        t_rstrb = 2'b00;
        @(negedge clk);
        chk("t5_late_idle", dut_t.state, IDLE);

        repeat (2) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
